// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the accumulator <-> SRAM quantize/dequantize path.
//   - ori_width(): accumulator width derived from the operand width.
//   - VALS_PER_WORD_DEF: packed values per SRAM word for the default build.
//   - QMAX / QMIN: saturation bounds of the 32-bit packed format. The quantizer
//     clamps to these; the dequantizer only widens, so it never needs them.
//   - MAX_SHIFT: largest scale-restore shift the dequantizer applies.
//   - state_t: row-assembly FSM states.
// -----------------------------------------------------------------------------
package tpu_pkg;

  // Accumulator width: two operand products plus 5 guard bits.
  function automatic int ori_width(input int data_width);
    return 2 * data_width + 5;
  endfunction

  localparam int DATA_WIDTH_DEF        = 16;
  localparam int ORI_WIDTH_DEF         = ori_width(DATA_WIDTH_DEF);
  localparam int SRAM_DATA_WIDTH_DEF   = 64;
  localparam int OUTPUT_DATA_WIDTH_DEF = 32;
  localparam int VALS_PER_WORD_DEF     = SRAM_DATA_WIDTH_DEF / OUTPUT_DATA_WIDTH_DEF;

  localparam logic signed [31:0] QMAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] QMIN = 32'sh8000_0000;

  // A 32-bit value shifted left by 5 exactly fills a 37-bit accumulator.
  localparam logic [2:0] MAX_SHIFT = 3'd5;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/dequantize_lane_ext.sv
// -----------------------------------------------------------------------------
// dequantize_lane_ext
// Combinational widening of one packed quantized value to accumulator format:
// sign-extend IN_WIDTH -> OUT_WIDTH, then arithmetic left shift by
// min(shift_amt, MAX_SHIFT). With the default widths (32 -> 37) the shifted
// result always fits, so no saturation is required.
// Ports:
//   in_val    in  IN_WIDTH   packed signed value
//   shift_amt in  3          requested scale shift (6 and 7 clamp to 5)
//   out_val   out OUT_WIDTH  widened, scaled value
// -----------------------------------------------------------------------------
module dequantize_lane_ext
  import tpu_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 37
) (
  input  logic [IN_WIDTH-1:0]  in_val,
  input  logic [2:0]           shift_amt,
  output logic [OUT_WIDTH-1:0] out_val
);

  logic [OUT_WIDTH-1:0] ext_s;
  logic [2:0]           clamp_s;

  // Sign-extend, clamp the shift, then scale; a left shift is identical for
  // logical and arithmetic interpretation once the value is already widened.
  always_comb begin
    ext_s   = {{(OUT_WIDTH - IN_WIDTH){in_val[IN_WIDTH-1]}}, in_val};
    clamp_s = (shift_amt > MAX_SHIFT) ? MAX_SHIFT : shift_amt;
    out_val = ext_s << clamp_s;
  end

endmodule

// File: rtl/dequantize_unpack.sv
// -----------------------------------------------------------------------------
// dequantize_unpack
// Reads packed 32-bit quantized results from SRAM words and rebuilds one
// ARRAY_SIZE-wide row of 37-bit accumulator values, which is then offered to
// the systolic array as a psum/bias preload row.
//
// Operation: in FILL every accepted word writes VALS_PER_WORD lanes (lower word
// bits -> lower lane index). After WORDS_PER_ROW words the block moves to HOLD
// and presents the row until out_ready; row_done pulses on that handshake.
// No input is accepted while HOLD is active.
//
// Optional feature: define DEQUANTIZE_SHIFT_EN to add port shift_amt; each
// accepted word's values are then shifted left by min(shift_amt, 5).
// Without the macro the shift is 0 and timing is identical.
//
// Ports:
//   clk        in   1                      rising-edge clock
//   rst        in   1                      synchronous, active-high reset
//   in_data    in   SRAM_DATA_WIDTH        packed quantized values
//   in_valid   in   1                      in_data valid
//   in_ready   out  1                      word accepted this cycle (FILL)
//   shift_amt  in   3                      (DEQUANTIZE_SHIFT_EN only)
//   out_row    out  ARRAY_SIZE*ORI_WIDTH   lane i at [i*ORI_WIDTH +: ORI_WIDTH]
//   out_valid  out  1                      out_row holds a complete row
//   out_ready  in   1                      consumer takes out_row
//   row_done   out  1                      one-cycle pulse on row handshake
// -----------------------------------------------------------------------------
module dequantize_unpack
  import tpu_pkg::*;
#(
  parameter int ARRAY_SIZE        = 32,
  parameter int SRAM_DATA_WIDTH   = 64,
  parameter int DATA_WIDTH        = 16,
  parameter int OUTPUT_DATA_WIDTH = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [SRAM_DATA_WIDTH-1:0]                     in_data,
  input  logic                                           in_valid,
  output logic                                           in_ready,
`ifdef DEQUANTIZE_SHIFT_EN
  input  logic [2:0]                                     shift_amt,
`endif
  output logic [ARRAY_SIZE*ori_width(DATA_WIDTH)-1:0]    out_row,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           row_done
);

  localparam int ORI_WIDTH     = ori_width(DATA_WIDTH);
  localparam int VALS_PER_WORD = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH;
  localparam int WORDS_PER_ROW = ARRAY_SIZE / VALS_PER_WORD;
  localparam int CNT_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);

  state_t             state_r;
  logic [CNT_W-1:0]   word_cnt_r;
  logic [2:0]         shift_s;
  logic [ORI_WIDTH-1:0] lane_val_s [VALS_PER_WORD];

`ifdef DEQUANTIZE_SHIFT_EN
  assign shift_s = shift_amt;
`else
  assign shift_s = 3'd0;
`endif

  // One widening unit per packed value in an SRAM word.
  for (genvar k = 0; k < VALS_PER_WORD; k++) begin : g_ext
    dequantize_lane_ext #(
      .IN_WIDTH  (OUTPUT_DATA_WIDTH),
      .OUT_WIDTH (ORI_WIDTH)
    ) u_ext (
      .in_val    (in_data[k*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]),
      .shift_amt (shift_s),
      .out_val   (lane_val_s[k])
    );
  end

  // Row-assembly FSM: word counter, lane register file and registered handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FILL;
      word_cnt_r <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      row_done   <= 1'b0;
      out_row    <= '0;
    end else begin
      row_done <= 1'b0;
      case (state_r)
        FILL: begin
          if (in_valid && in_ready) begin
            // Lanes are indexed by word position; word_cnt selects the slot.
            for (int k = 0; k < VALS_PER_WORD; k++) begin
              out_row[(int'(word_cnt_r) * VALS_PER_WORD + k) * ORI_WIDTH +: ORI_WIDTH]
                <= lane_val_s[k];
            end
            if (word_cnt_r == LAST_WORD) begin
              word_cnt_r <= '0;
              state_r    <= HOLD;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
            end else begin
              word_cnt_r <= word_cnt_r + CNT_W'(1);
            end
          end else begin
            word_cnt_r <= word_cnt_r;
          end
        end
        HOLD: begin
          // Lane registers are left as-is; the next fill overwrites them.
          if (out_ready) begin
            state_r   <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            row_done  <= 1'b1;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r    <= FILL;
          word_cnt_r <= '0;
          in_ready   <= 1'b1;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dequantize_unpack.sv
// -----------------------------------------------------------------------------
// tb_dequantize_unpack
// Randomized stimulus with a scoreboard: the driver records every accepted
// word; each completed group of 16 words turns into an expected row computed
// with plain signed arithmetic and is queued. An independent monitor pops and
// compares on every output handshake and checks the row_done pulse.
// -----------------------------------------------------------------------------
module tb_dequantize_unpack;

  localparam int AS  = 32;
  localparam int OW  = 37;
  localparam int WPR = 16;

  typedef logic [AS*OW-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  row_t          out_row;
  logic          out_valid;
  logic          out_ready;
  logic          row_done;
`ifdef DEQUANTIZE_SHIFT_EN
  logic [2:0]    shift_amt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  row_t        sb[$];
  logic [63:0] cur_words[$];
  int          cur_sh[$];

  dequantize_unpack dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DEQUANTIZE_SHIFT_EN
    .shift_amt (shift_amt),
`endif
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .row_done  (row_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] lane_of(input row_t r, input int i);
    return r[i*OW +: OW];
  endfunction

  // Reference: value as a signed integer, times 2^min(sh,5), kept to 37 bits.
  function automatic logic [OW-1:0] model_lane(input logic [31:0] v, input int sh);
    longint x;
    int s;
    s = (sh > 5) ? 5 : sh;
    x = longint'($signed(v)) * (longint'(1) << s);
    return x[OW-1:0];
  endfunction

  function automatic row_t model_row();
    row_t r;
    logic [63:0] w;
    r = '0;
    for (int i = 0; i < AS; i++) begin
      w = cur_words[i / 2];
      r[i*OW +: OW] = model_lane(w[32*(i % 2) +: 32], cur_sh[i / 2]);
    end
    return r;
  endfunction

  // Offer one word after 'gap' idle cycles; record it in the model once accepted.
  task automatic send_word(input logic [63:0] d, input int sh, input int gap);
    bit hs;
    hs = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
`ifdef DEQUANTIZE_SHIFT_EN
    shift_amt = 3'(sh);
`endif
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    if (!hs) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      cur_words.push_back(d);
`ifdef DEQUANTIZE_SHIFT_EN
      cur_sh.push_back(sh);
`else
      cur_sh.push_back(0);
`endif
      if (cur_words.size() == WPR) begin
        sb.push_back(model_row());
        cur_words.delete();
        cur_sh.delete();
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !out_valid;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_row_done", 64'(row_done), 64'd0);
    n_checks++;
    if (out_row !== '0) begin
      n_fail++;
      $display("FAIL rst_out_row: lane0 got %h expected 0", lane_of(out_row, 0));
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare rows on handshake, check row_done follows it by one cycle.
  initial begin
    bit   prev_hs;
    row_t e;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hs = 1'b0;
      end else begin
        chk("row_done", 64'(row_done), 64'(prev_hs));
        prev_hs = out_valid && out_ready;
        if (prev_hs) begin
          if (sb.size() == 0) begin
            chk("unexpected_row", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            n_checks++;
            if (out_row !== e) begin
              n_fail++;
              for (int i = 0; i < AS; i++) begin
                if (lane_of(out_row, i) !== lane_of(e, i)) begin
                  $display("FAIL row_data lane %0d: got %h expected %h", i,
                           lane_of(out_row, i), lane_of(e, i));
                  break;
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t snap;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 64'd0;
`ifdef DEQUANTIZE_SHIFT_EN
    shift_amt = 3'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // Basic row: lane i = i+1, back-to-back words.
    ready_mode = 1;
    for (int w = 0; w < WPR; w++)
      send_word({32'(2*w + 2), 32'(2*w + 1)}, 0, 0);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    chk("basic_lane0", 64'(lane_of(out_row, 0)), 64'd1);
    chk("basic_lane31", 64'(lane_of(out_row, 31)), 64'd32);
    drain();

    // Sign extension corners.
    send_word({32'h7FFF_FFFF, 32'h8000_0000}, 0, 0);
    send_word({32'hFFFF_FFFF, 32'h0000_0001}, 0, 0);
    for (int w = 2; w < WPR; w++) send_word({$urandom, $urandom}, 0, 0);
    chk("sext_lane0", 64'(lane_of(out_row, 0)), 64'h1F_8000_0000);
    chk("sext_lane1", 64'(lane_of(out_row, 1)), 64'h00_7FFF_FFFF);
    chk("sext_lane3", 64'(lane_of(out_row, 3)), 64'h1F_FFFF_FFFF);
    drain();

    // Random rows, random gaps and random consumer backpressure.
    ready_mode = 2;
    for (int r = 0; r < 6; r++)
      for (int w = 0; w < WPR; w++)
        send_word({$urandom, $urandom}, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    drain();
    ready_mode = 1;
    drain();

    // Long backpressure: row must stay frozen and no word accepted.
    ready_mode = 0;
    @(posedge clk);
    #1;
    for (int w = 0; w < WPR; w++)
      send_word({$urandom, $urandom}, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    snap = out_row;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid_hold", 64'(out_valid), 64'd1);
      n_checks++;
      if (out_row !== snap) begin
        n_fail++;
        $display("FAIL bp_stable: lane0 got %h expected %h", lane_of(out_row, 0), lane_of(snap, 0));
      end
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ready_mode = 1;
    for (int w = 0; w < WPR; w++)
      send_word({$urandom, $urandom}, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
    drain();

    // Reset in the middle of a fill.
    for (int w = 0; w < 7; w++) send_word({$urandom, $urandom}, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur_words.delete();
    cur_sh.delete();
    check_reset_state();
    for (int w = 0; w < WPR; w++) send_word({$urandom, $urandom}, 0, int'($urandom_range(0, 1)));
    drain();

`ifdef DEQUANTIZE_SHIFT_EN
    // Scale restore: 5 and clamped 7 behave alike, 0 is a plain extension.
    send_word({32'h0000_0001, 32'h8000_0000}, 5, 0);
    send_word({32'h0000_0001, 32'h8000_0000}, 7, 0);
    send_word({32'h0000_0001, 32'h8000_0000}, 0, 0);
    for (int w = 3; w < WPR; w++) send_word({$urandom, $urandom}, 0, 0);
    chk("shift5_lane0", 64'(lane_of(out_row, 0)), 64'h10_0000_0000);
    chk("shift5_lane1", 64'(lane_of(out_row, 1)), 64'd32);
    chk("shift7_lane2", 64'(lane_of(out_row, 2)), 64'h10_0000_0000);
    chk("shift0_lane4", 64'(lane_of(out_row, 4)), 64'h1F_8000_0000);
    drain();
`endif

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
